// File: rtl/antirrebote_boton_pkg.sv
// rtl/antirrebote_boton_pkg.sv - shared constants and state encoding for button conditioning stages
`timescale 1ns/1ps
package antirrebote_boton_pkg;

    // Debouncer FSM encoding, shared by every button stage
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        PRESSED      = 2'b10,
        WAIT_RELEASE = 2'b11
    } estado_t;

    localparam int CLK_HZ              = 50_000_000;
    // 10 ms of stability at the system clock
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;

    // True when a counter of width w can reach n-1 without wrapping
    function automatic bit cnt_w_ok(input int w, input int n);
        return (64'(1) << w) >= 64'(n);
    endfunction

endpackage

// File: rtl/antirrebote_boton_sincronizador_2ff.sv
// rtl/antirrebote_boton_sincronizador_2ff.sv - generic 1-bit two-flop synchronizer
`timescale 1ns/1ps
module sincronizador_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage chain; only q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/antirrebote_boton.sv
// rtl/antirrebote_boton.sv - push-button synchronizer, debouncer and press/release strobe generator
`timescale 1ns/1ps
module antirrebote_boton
    import antirrebote_boton_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    generate
        if (DEBOUNCE_CYCLES < 1 || !cnt_w_ok(CNT_W, DEBOUNCE_CYCLES)) begin : g_param_err
            $error("antirrebote_boton: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    estado_t          estado, estado_sig;
    logic [CNT_W-1:0] cnt, cnt_sig;
    logic             level_sig, pulse_sig, release_sig;
    logic             fin_cuenta;

    sincronizador_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );

    assign fin_cuenta = (cnt == CNT_LIMIT);

    // State, stability counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado      <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            estado      <= estado_sig;
            cnt         <= cnt_sig;
            btn_level   <= level_sig;
            btn_pulse   <= pulse_sig;
            btn_release <= release_sig;
        end
    end

    // Next state: a change must persist for DEBOUNCE_CYCLES before it is accepted;
    // any reversal during a WAIT state drops back without touching the level
    always_comb begin
        estado_sig  = estado;
        cnt_sig     = cnt;
        level_sig   = btn_level;
        pulse_sig   = 1'b0;
        release_sig = 1'b0;
        case (estado)
            IDLE: begin
                if (s) begin
                    estado_sig = WAIT_PRESS;
                    cnt_sig    = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    estado_sig = IDLE;
                end else if (fin_cuenta) begin
                    estado_sig = PRESSED;
                    level_sig  = 1'b1;
                    pulse_sig  = 1'b1;
                end else begin
                    cnt_sig = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    estado_sig = WAIT_RELEASE;
                    cnt_sig    = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    estado_sig = PRESSED;
                end else if (fin_cuenta) begin
                    estado_sig  = IDLE;
                    level_sig   = 1'b0;
                    release_sig = 1'b1;
                end else begin
                    cnt_sig = cnt + CNT_W'(1);
                end
            end
            default: begin
                estado_sig = IDLE;
                level_sig  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_antirrebote_boton.sv
// tb/tb_antirrebote_boton.sv - scoreboard bench for antirrebote_boton with N=4
`timescale 1ns/1ps
module tb_antirrebote_boton;

    localparam int N   = 4;
    localparam int LAT = N + 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, btn_pulse, btn_release;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        bit         is_release;
        int         cyc;
        logic [1:0] cnt;
    } ev_t;

    ev_t        sb[$];
    logic [1:0] cont_2b = 2'd0;
    logic [1:0] exp_seq [5];

    antirrebote_boton #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_press();
        ev_t e;
        e.is_release = 1'b0;
        e.cyc        = cyc + LAT;
        e.cnt        = exp_seq[0];
        sb.push_back(e);
    endtask

    task automatic push_release();
        ev_t e;
        e.is_release = 1'b1;
        e.cyc        = cyc + LAT;
        e.cnt        = 2'd0;
        sb.push_back(e);
    endtask

    int press_idx = 0;

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        ev_t e;
        if (btn_pulse || btn_release) begin
            chk("pulse_and_release_exclusive", int'(btn_pulse && btn_release), 0);
            if (btn_pulse) cont_2b = cont_2b + 2'd1;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", int'({btn_pulse, btn_release}), 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind_release", int'(btn_release), int'(e.is_release));
                chk("strobe_cycle", cyc, e.cyc);
                chk("level_at_strobe", int'(btn_level), int'(!e.is_release));
                if (!e.is_release) begin
                    chk("counter_value", int'(cont_2b), int'(exp_seq[press_idx]));
                    press_idx++;
                end
            end
        end
    end

    initial begin
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
        rst    = 1'b0;
        btn_in = 1'b0;
        step(3);
        chk("reset_level", int'(btn_level), 0);
        chk("reset_pulse", int'(btn_pulse), 0);
        chk("reset_release", int'(btn_release), 0);
        rst = 1'b1;
        step(2);

        // Clean press
        btn_in = 1'b1;
        push_press();
        step(LAT - 1);
        chk("clean_level_before", int'(btn_level), 0);
        step(1);
        chk("clean_pulse_at_edge7", int'(btn_pulse), 1);
        step(1);
        chk("clean_pulse_low_edge8", int'(btn_pulse), 0);
        chk("clean_level_held", int'(btn_level), 1);
        step(3);

        // Clean release
        btn_in = 1'b0;
        push_release();
        step(LAT + 2);
        chk("release_level", int'(btn_level), 0);

        // Bouncing press, then held
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0);
            step(2);
        end
        chk("bounce_level_low", int'(btn_level), 0);
        btn_in = 1'b1;
        push_press();
        step(LAT + 3);
        chk("bounce_level_high", int'(btn_level), 1);

        // Short release glitch must be absorbed
        btn_in = 1'b0;
        step(2);
        btn_in = 1'b1;
        step(10);
        chk("glitch_level_held", int'(btn_level), 1);

        btn_in = 1'b0;
        push_release();
        step(LAT + 2);
        chk("release2_level", int'(btn_level), 0);

        // Reset while WAIT_PRESS has cnt=2, button kept pressed
        btn_in = 1'b1;
        step(5);
        rst = 1'b0;
        #1;
        chk("midcount_rst_level", int'(btn_level), 0);
        chk("midcount_rst_pulse", int'(btn_pulse), 0);
        step(2);
        rst = 1'b1;
        push_press();
        step(LAT + 2);
        chk("after_rst_level", int'(btn_level), 1);

        // Async reset while PRESSED clears level without waiting for an edge
        rst = 1'b0;
        #2;
        chk("async_rst_level", int'(btn_level), 0);
        chk("async_rst_release", int'(btn_release), 0);
        btn_in = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);

        // Two more presses to complete the counter sequence
        for (int p = 0; p < 2; p++) begin
            btn_in = 1'b1;
            push_press();
            step(LAT + 2);
            btn_in = 1'b0;
            push_release();
            step(LAT + 2);
        end

        step(5);
        chk("scoreboard_drained", sb.size(), 0);
        chk("press_count", press_idx, 5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/antirrebote_boton.md
Name: antirrebote_boton

Overview:
Button conditioning stage that sits directly upstream of the 2-bit press counter. It synchronizes a raw mechanical push-button into the clk domain, debounces it with a stability timer and a 4-state FSM, and produces a clean debounced level plus one-cycle press and release strobes. btn_pulse drives the counter's up input, so the counter advances exactly once per physical press.

Parameters:
DEBOUNCE_CYCLES, 500000, clk cycles the synchronized input must stay stable before a change is accepted (10 ms at 50 MHz); must be >= 1, elaboration error otherwise
CNT_W, 19, width of the stability counter; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
btn_in  input  1  raw button, asynchronous to clk, active-high (1 = pressed)
btn_level  output  1  debounced button level, registered
btn_pulse  output  1  one-cycle strobe on an accepted press, registered
btn_release  output  1  one-cycle strobe on an accepted release, registered

Behaviour:
- Reset: rst low asynchronously clears both synchronizer FFs, the counter, and all outputs; state = IDLE. Reset asserted mid-count aborts the count, and no strobe is produced.
- Synchronizer: 2-FF chain; s = second FF output. Only s feeds the FSM.
- IDLE (level 0): on s=1, go to WAIT_PRESS with cnt <= 0.
- WAIT_PRESS: on s=0, return to IDLE (bounce rejected, no strobe). On cnt == DEBOUNCE_CYCLES-1, go to PRESSED. Otherwise cnt <= cnt+1.
- PRESSED (level 1): on s=0, go to WAIT_RELEASE with cnt <= 0.
- WAIT_RELEASE: on s=1, return to PRESSED (no strobe). On cnt == DEBOUNCE_CYCLES-1, go to IDLE. Otherwise cnt <= cnt+1.
- Outputs on state transitions:
  - Entering PRESSED from WAIT_PRESS: btn_level and btn_pulse rise on the same edge; btn_pulse is high for exactly one cycle.
  - Entering IDLE from WAIT_RELEASE: btn_level falls and btn_release is high for exactly one cycle on that edge.
  - btn_level is held at its old value during both WAIT states.
- Latency: btn_in stably high; the first edge sampling it high is edge 1. btn_level and btn_pulse rise at edge DEBOUNCE_CYCLES+3 (2 sync + 1 detect + N count). Release is symmetric.
- A glitch shorter than DEBOUNCE_CYCLES of synchronized time never changes btn_level. Each return to a WAIT state restarts the count from 0.
- Button held across reset deassertion is treated as a fresh press: a full debounce runs, then one btn_pulse.
- Held button produces no further pulses. btn_pulse and btn_release are never high in the same cycle.
- Counter never wraps: it stops at DEBOUNCE_CYCLES-1 by construction.

Decomposition:
- Shared constants file (included by this block and future button stages): FSM state encodings IDLE=2'b00, WAIT_PRESS=2'b01, PRESSED=2'b10, WAIT_RELEASE=2'b11; CLK_HZ=50000000; default DEBOUNCE_CYCLES derived as CLK_HZ/100.
- Sub-module sincronizador_2ff: generic 1-bit two-flop synchronizer with async active-low reset to 0. Reused for any other asynchronous input.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=4): rst low 3 cycles, then high; btn_in 0->1 held -> btn_level and btn_pulse rise at edge 7 after first sample; btn_pulse low at edge 8; btn_level stays 1.
- Bounce on press (N=4): btn_in 1,0,1,0 toggling every 2 cycles, then held high -> no btn_pulse during bouncing; exactly one btn_pulse 7 edges after the final stable 1.
- Release (N=4): from PRESSED, btn_in 1->0 held -> btn_level falls and btn_release high 1 cycle at edge 7; btn_pulse stays 0.
- Short release glitch (N=4): in PRESSED, btn_in low 2 cycles then high -> btn_level stays 1; no btn_release, no btn_pulse.
- Reset mid-count (N=4): assert rst while in WAIT_PRESS with cnt=2 -> all outputs 0 immediately, asynchronously. Release rst with btn_in held high -> one btn_pulse at edge 7 after reset release.
- Integration with contador_2b (N=4): 5 clean presses -> counter sequence 1,2,3,0,1; exactly one increment per press.
